read_loader: RTL

//  Upstream feeder for systolic_array. Accepts reference (x) and experimental (y) strings plus y

---
 rtl/read_loader_pkg.sv | 36 +++
 rtl/read_loader_phred_rom.sv | 23 ++
 rtl/read_loader.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/read_loader_pkg.sv
// Shared types for the systolic_array feed path: base encoding, read/prior words, storage depth.
package read_loader_pkg;

    localparam int MAX_STRING_LENGTH = 16;

    typedef enum logic [2:0] {
        STRING_A,
        STRING_C,
        STRING_G,
        STRING_T,
        STRING_DASH
    } STRING;

    typedef struct packed {
        STRING reference;
        STRING exp;
        logic  valid;
    } READS;

    typedef struct packed {
        logic [63:0] match;
        logic [63:0] neq;
        logic        valid;
    } PRIORS;

    function automatic STRING encode_base(input logic [7:0] c);
        case (c)
            8'h41:   return STRING_A;
            8'h43:   return STRING_C;
            8'h47:   return STRING_G;
            8'h54:   return STRING_T;
            default: return STRING_DASH;
        endcase
    endfunction

endpackage

// File: rtl/read_loader_phred_rom.sv
// Phred quality ROM: q -> {match, neq} as IEEE-754 doubles, neq = 10^(-q/10), match = 1 - neq.
module phred_rom (
    input  logic [6:0]   q,
    output logic [127:0] prior
);

    // Evaluated at elaboration only; the table itself is plain constant bits.
    function automatic logic [127:0] phred_entry(input int unsigned idx);
        real neq;
        neq = 10.0 ** (-real'(idx) / 10.0);
        return {$realtobits(1.0 - neq), $realtobits(neq)};
    endfunction

    logic [127:0] table_w [128];

    for (genvar i = 0; i < 128; i++) begin : g_entry
        localparam logic [127:0] ENTRY = phred_entry(i);
        assign table_w[i] = ENTRY;
    end

    assign prior = table_w[q];

endmodule

// File: rtl/read_loader.sv
// Loads x/y strings and y qualities byte-serially, then serves systolic_array read requests.
module read_loader
    import read_loader_pkg::*;
#(
    parameter int MAX_LEN = MAX_STRING_LENGTH,
    parameter int LW      = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [7:0]    load_base,
    input  logic [7:0]    load_qual,
    input  logic          load_last,
    output logic          array_hold,
    output logic [LW-1:0] string_length,
    output logic [LW-1:0] y_length,
    input  logic [LW-1:0] read_index_x,
    input  logic          read_x_valid,
    input  logic [LW-1:0] read_index_y,
    input  logic          read_y_valid,
    output READS          base_reads,
    output PRIORS         prior_reads,
    input  logic          complete,
    input  logic [63:0]   final_val,
    output logic [63:0]   result,
    output logic          result_valid,
    output logic          err_overflow
);

    localparam logic [1:0] LOAD_X = 2'd0;
    localparam logic [1:0] LOAD_Y = 2'd1;
    localparam logic [1:0] SERVE  = 2'd2;

    localparam logic [LW-1:0] CNT_MAX = LW'(MAX_LEN - 1);

    logic [1:0]    state_q;
    logic [LW-1:0] cnt_q;
    logic          accept;
    logic          full;
    logic [LW-1:0] len_next;
    logic          y_in_range;
    logic [127:0]  rom_word;
    logic          unused_qual_msb;

    STRING      x_mem [MAX_LEN];
    STRING      y_mem [MAX_LEN];
    logic [6:0] q_mem [MAX_LEN];

    assign accept     = load_valid && load_ready && (state_q == LOAD_X || state_q == LOAD_Y);
    assign full       = (cnt_q == CNT_MAX);
    assign len_next   = full ? CNT_MAX : cnt_q + LW'(1);
    assign y_in_range = (read_index_y < y_length);

    assign unused_qual_msb = load_qual[7];

    phred_rom u_phred_rom (
        .q     (q_mem[read_index_y]),
        .prior (rom_word)
    );

    // Storage is deliberately left out of reset; reads are gated by the lengths.
    always_ff @(posedge clk) begin
        if (accept && !full) begin
            if (state_q == LOAD_X) begin
                x_mem[cnt_q] <= encode_base(load_base);
            end else begin
                y_mem[cnt_q] <= encode_base(load_base);
                q_mem[cnt_q] <= load_qual[6:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= LOAD_X;
            cnt_q         <= '0;
            load_ready    <= 1'b0;
            array_hold    <= 1'b1;
            string_length <= '0;
            y_length      <= '0;
            base_reads    <= '0;
            prior_reads   <= '0;
            result        <= '0;
            result_valid  <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state_q)
                LOAD_X, LOAD_Y: begin
                    load_ready <= 1'b1;
                    if (accept) begin
                        // Bytes past capacity are consumed but dropped.
                        if (full) err_overflow <= 1'b1;
                        else      cnt_q <= cnt_q + LW'(1);
                        if (load_last) begin
                            cnt_q <= '0;
                            if (state_q == LOAD_X) begin
                                string_length <= len_next;
                                state_q       <= LOAD_Y;
                            end else begin
                                y_length   <= len_next;
                                state_q    <= SERVE;
                                load_ready <= 1'b0;
                                array_hold <= 1'b0;
                            end
                        end
                    end
                end
                SERVE: begin
                    if (complete) begin
                        result            <= final_val;
                        result_valid      <= 1'b1;
                        array_hold        <= 1'b1;
                        load_ready        <= 1'b1;
                        base_reads.valid  <= 1'b0;
                        prior_reads.valid <= 1'b0;
                        string_length     <= '0;
                        y_length          <= '0;
                        state_q           <= LOAD_X;
                    end else begin
                        if (read_x_valid) begin
                            base_reads.reference <= (read_index_x < string_length) ?
                                                    x_mem[read_index_x] : STRING_DASH;
                            base_reads.valid     <= 1'b1;
                        end
                        if (read_y_valid) begin
                            base_reads.exp    <= y_in_range ? y_mem[read_index_y] : STRING_DASH;
                            prior_reads.match <= y_in_range ? rom_word[127:64] : 64'h0;
                            prior_reads.neq   <= y_in_range ? rom_word[63:0] : 64'h0;
                            prior_reads.valid <= 1'b1;
                        end
                    end
                end
                default: state_q <= LOAD_X;
            endcase
        end
    end

endmodule
